// File: rtl/lr_input_loader_if.sv
// lr_input_loader_if: entry controls and packed regression matrices between user front-end and loader
interface lr_input_loader_if #(
  parameter int ELEM_WIDTH  = 14,
  parameter int NUM_SAMPLES = 3
);
  localparam int CW = $clog2(2 * NUM_SAMPLES + 1);
  logic                              enter;
  logic                              input_done;
  logic [ELEM_WIDTH-1:0]             data_in;
  logic [NUM_SAMPLES*2*ELEM_WIDTH-1:0] x_data;
  logic [NUM_SAMPLES*ELEM_WIDTH-1:0]   y_data;
  logic                              error;
  logic                              ready;
  logic [CW-1:0]                     count;
  logic                              expect_y;
  modport master (
    output enter, input_done, data_in,
    input  x_data, y_data, error, ready, count, expect_y
  );
  modport slave (
    input  enter, input_done, data_in,
    output x_data, y_data, error, ready, count, expect_y
  );
endinterface

// File: rtl/lr_input_loader.sv
// lr_input_loader: collects range-checked (x, y) pairs into the X matrix (with ones column) and y vector
module lr_input_loader #(
  parameter int ELEM_WIDTH  = 14,
  parameter int NUM_SAMPLES = 3,
  parameter int MAX_VALUE   = 99
) (
  input logic clk,
  input logic rst,
  lr_input_loader_if.slave bus
);
  localparam int W  = ELEM_WIDTH;
  localparam int N  = NUM_SAMPLES;
  localparam int CW = $clog2(2 * N + 1);
  localparam logic [CW-1:0] FULL = CW'(2 * N);
  localparam logic [W-1:0]  MAXV = W'(MAX_VALUE);
  function automatic logic [2*N*W-1:0] ones_column();
    logic [2*N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[(2*i+1)*W +: W] = W'(1);
    return r;
  endfunction
  localparam logic [2*N*W-1:0] X_RST = ones_column();
  typedef enum logic [1:0] {COLLECT, READY, ERROR} state_t;
  state_t           state, state_n;
  logic             enter_prev, enter_pulse;
  logic [2*N*W-1:0] x_q, x_n;
  logic [N*W-1:0]   y_q, y_n;
  logic [CW-1:0]    cnt_q, cnt_n, idx;
  logic             ey_q, ey_n, err_q, err_n, rdy_q, rdy_n;
  assign enter_pulse = bus.enter & ~enter_prev;
  assign idx         = cnt_q >> 1;
  // next-state: enter edges take priority over input_done; READY and ERROR only leave on reset
  always_comb begin
    state_n = state;
    x_n     = x_q;
    y_n     = y_q;
    cnt_n   = cnt_q;
    ey_n    = ey_q;
    err_n   = err_q;
    rdy_n   = rdy_q;
    if (state == COLLECT) begin
      if (enter_pulse) begin
        if (bus.data_in > MAXV || cnt_q == FULL) begin
          err_n   = 1'b1;
          state_n = ERROR;
        end else begin
          if (ey_q) y_n[idx*W +: W] = bus.data_in;
          else x_n[idx*2*W +: W] = bus.data_in;
          cnt_n = cnt_q + 1'b1;
          ey_n  = ~ey_q;
        end
      end else if (bus.input_done) begin
        state_n = (cnt_q == FULL) ? READY : ERROR;
        rdy_n   = (cnt_q == FULL);
        err_n   = (cnt_q != FULL);
      end
    end
  end
  // registered state, data and edge-detect
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      enter_prev <= 1'b0;
      x_q        <= X_RST;
      y_q        <= '0;
      cnt_q      <= '0;
      ey_q       <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state      <= state_n;
      enter_prev <= bus.enter;
      x_q        <= x_n;
      y_q        <= y_n;
      cnt_q      <= cnt_n;
      ey_q       <= ey_n;
      err_q      <= err_n;
      rdy_q      <= rdy_n;
    end
  end
  assign bus.x_data   = x_q;
  assign bus.y_data   = y_q;
  assign bus.count    = cnt_q;
  assign bus.expect_y = ey_q;
  assign bus.error    = err_q;
  assign bus.ready    = rdy_q;
endmodule

// File: tb/tb_lr_input_loader.sv
// tb_lr_input_loader: directed and randomized entry sequences checked against a queue-based model
module tb_lr_input_loader;
  localparam int W = 14;
  localparam int N = 3;
  logic clk, rst;
  int total = 0;
  int bad = 0;
  lr_input_loader_if #(.ELEM_WIDTH(W), .NUM_SAMPLES(N)) bus ();
  lr_input_loader #(.ELEM_WIDTH(W), .NUM_SAMPLES(N), .MAX_VALUE(99)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  logic [W-1:0] vals[$];
  bit m_err, m_rdy;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_clear();
    vals.delete();
    m_err = 0;
    m_rdy = 0;
  endtask
  task automatic m_press(input logic [W-1:0] v);
    if (m_err || m_rdy) return;
    if (v > 99 || vals.size() == 2 * N) m_err = 1;
    else vals.push_back(v);
  endtask
  task automatic m_done();
    if (m_err || m_rdy) return;
    if (vals.size() == 2 * N) m_rdy = 1;
    else m_err = 1;
  endtask
  task automatic check_all(input string tag);
    logic [2*N*W-1:0] ex;
    logic [N*W-1:0] ey;
    ex = '0;
    ey = '0;
    for (int k = 0; k < N; k++) begin
      if (2 * k < vals.size()) ex[2*k*W +: W] = vals[2*k];
      ex[(2*k+1)*W +: W] = 1;
      if (2 * k + 1 < vals.size()) ey[k*W +: W] = vals[2*k+1];
    end
    chk({tag, ".x_data"}, 128'(bus.x_data), 128'(ex));
    chk({tag, ".y_data"}, 128'(bus.y_data), 128'(ey));
    chk({tag, ".count"}, 128'(bus.count), 128'(vals.size()));
    chk({tag, ".expect_y"}, 128'(bus.expect_y), 128'(vals.size() % 2));
    chk({tag, ".error"}, 128'(bus.error), 128'(m_err));
    chk({tag, ".ready"}, 128'(bus.ready), 128'(m_rdy));
  endtask
  task automatic do_reset(input string tag);
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    m_clear();
    check_all(tag);
  endtask
  task automatic press(input logic [W-1:0] v, input string tag);
    @(negedge clk);
    bus.data_in = v;
    bus.enter = 1;
    @(negedge clk) bus.enter = 0;
    m_press(v);
    check_all(tag);
  endtask
  task automatic done(input string tag);
    @(negedge clk) bus.input_done = 1;
    @(negedge clk) bus.input_done = 0;
    m_done();
    check_all(tag);
  endtask
  task automatic press_done(input logic [W-1:0] v, input int hold, input string tag);
    @(negedge clk);
    bus.data_in = v;
    bus.enter = 1;
    bus.input_done = 1;
    @(negedge clk) bus.enter = 0;
    if (hold < 2) bus.input_done = 0;
    m_press(v);
    check_all({tag, ".edge"});
    if (hold >= 2) begin
      @(negedge clk) bus.input_done = 0;
      m_done();
      check_all({tag, ".done"});
    end
  endtask
  initial begin
    int n;
    logic [W-1:0] v;
    rst = 1;
    bus.enter = 0;
    bus.input_done = 0;
    bus.data_in = 0;
    m_clear();
    repeat (2) @(negedge clk);
    rst = 0;
    check_all("reset");
    foreach (vals[i]) chk("never", 1, 0);
    press(2, "nom"); press(3, "nom"); press(5, "nom");
    press(6, "nom"); press(8, "nom"); press(9, "nom");
    done("nom_done");
    chk("nom_rows", 128'(bus.x_data), 128'({14'd1, 14'd8, 14'd1, 14'd5, 14'd1, 14'd2}));
    chk("nom_y", 128'(bus.y_data), 128'({14'd9, 14'd6, 14'd3}));
    press(7, "ready_frozen");
    done("ready_frozen_done");
    do_reset("held_reset");
    @(negedge clk);
    bus.data_in = 4;
    bus.enter = 1;
    repeat (10) @(negedge clk);
    bus.enter = 0;
    m_press(4);
    check_all("held");
    chk("held_x0", 128'(bus.x_data[W-1:0]), 128'(4));
    do_reset("range_reset");
    press(2, "range");
    press(100, "range_bad");
    done("range_done");
    do_reset("early_reset");
    press(2, "early"); press(3, "early"); press(5, "early");
    done("early_done");
    press(1, "early_after"); press(2, "early_after");
    do_reset("ovf_reset");
    for (int i = 0; i < 2 * N; i++) press(W'(10 + i), "ovf");
    press_done(7, 1, "ovf_sim");
    do_reset("sim_reset");
    for (int i = 0; i < 2 * N - 1; i++) press(W'(20 + i), "sim");
    press_done(42, 2, "sim_last");
    do_reset("mid_reset");
    press(11, "mid"); press(12, "mid"); press(13, "mid");
    do_reset("mid_cleared");
    press(2, "renom"); press(3, "renom"); press(5, "renom");
    press(6, "renom"); press(8, "renom"); press(9, "renom");
    done("renom_done");
    for (int it = 0; it < 25; it++) begin
      do_reset("rnd_reset");
      n = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) begin
        v = ($urandom_range(0, 12) == 0) ? W'($urandom_range(100, 16383)) : W'($urandom_range(0, 99));
        if (i == n - 1 && $urandom_range(0, 1) == 1) press_done(v, $urandom_range(1, 2), "rnd_sim");
        else press(v, "rnd");
      end
      done("rnd_done");
      press(W'($urandom_range(0, 99)), "rnd_after");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lr_input_loader.md
Name: lr_input_loader

Overview:
- Serial front-end for the linear-regression datapath; feeds the transpose/multiply chain.
- Collects NUM_SAMPLES (x, y) pairs entered one value per `enter` press on `data_in`.
- Range-checks each value and packs the pairs into the X matrix (with a constant column of ones) and the y vector.
- Asserts `ready` once a complete, error-free set has been confirmed by `input_done`.

Parameters:
- ELEM_WIDTH, 14, width of each matrix element and of `data_in`.
- NUM_SAMPLES, 3, number of (x, y) pairs per regression.
- MAX_VALUE, 99, largest accepted unsigned input value; two-digit display limit.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- enter  input  1  entry strobe, level from a debounced button; its rising edge captures `data_in`.
- input_done  input  1  level; user confirms the entry set is complete.
- data_in  input  ELEM_WIDTH  unsigned value to capture.
- x_data  output  NUM_SAMPLES*2*ELEM_WIDTH  packed X matrix, NUM_SAMPLES rows by 2 columns.
- y_data  output  NUM_SAMPLES*ELEM_WIDTH  packed y vector.
- error  output  1  sticky input error flag.
- ready  output  1  matrices complete and valid; held high.
- count  output  $clog2(2*NUM_SAMPLES+1)  number of values accepted so far.
- expect_y  output  1  0 means the next value entered is x; 1 means it is y.

Behaviour:
- Clock and reset:
  - Single clock domain, rising edge of `clk`.
  - Reset is synchronous and active-high (`rst`).
  - Reset values: x_data has all x fields 0 and all ones-column fields 1; y_data = 0; error = 0; ready = 0; count = 0; expect_y = 0; enter edge-detect register = 0; state = COLLECT.
- Edge detection: `enter_prev` is registered every cycle. `enter_pulse = enter & ~enter_prev`. Holding `enter` high yields exactly one capture.
- Packing (sample k is 0-based, in entry order):
  - x_k goes to x_data[(2k)*ELEM_WIDTH +: ELEM_WIDTH].
  - The constant 1 goes to x_data[(2k+1)*ELEM_WIDTH +: ELEM_WIDTH].
  - y_k goes to y_data[k*ELEM_WIDTH +: ELEM_WIDTH].
  - Row k of x_data is therefore {1, x_k}, matching the downstream multiply indexing (i*COLS+k).
- Entry order: x0, y0, x1, y1, and so on. `expect_y` toggles on each accepted value. The sample index is count>>1.
- State COLLECT, evaluated on a cycle with `enter_pulse`:
  - If data_in > MAX_VALUE: error is set to 1, the value is not stored, count is unchanged, go to ERROR.
  - Else if count == 2*NUM_SAMPLES (buffer full): error is set to 1 (overflow), go to ERROR.
  - Else: the value is written to its field, count increments, expect_y toggles.
  - All updates are visible the cycle after the edge; latency is 1 cycle.
- State COLLECT, evaluated on a cycle with input_done=1 and no `enter_pulse`:
  - If count == 2*NUM_SAMPLES: go to READY, `ready` = 1 from the next cycle.
  - Else (early or odd count): error is set to 1, go to ERROR.
- Simultaneous events: if `enter_pulse` and `input_done` occur in the same cycle, `enter` is processed and `input_done` is ignored that cycle. If `input_done` is still high next cycle, it is evaluated then.
- State READY:
  - ready = 1; x_data and y_data are frozen.
  - `enter` and `input_done` are ignored.
  - Exits only on `rst`.
- State ERROR:
  - error = 1, ready = 0.
  - Stored data is retained but must be treated as invalid.
  - All inputs are ignored; exits only on `rst`.
- Reset mid-entry: all partially entered data is discarded and restored to reset values on the next edge.
- Widths and arithmetic:
  - All values are unsigned; the comparison against MAX_VALUE is unsigned.
  - No arithmetic is applied to stored values.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Nominal load: enter 2,3,5,6,8,9 with one press each, then input_done=1. Required: x_data rows {1,2},{1,5},{1,8}; y_data = {9,6,3} (MSB to LSB); ready=1 one cycle after input_done; error=0; count=6.
- Held button: keep enter high for 10 cycles with data_in=4. Required: exactly one capture, count=1, expect_y=1, x field 0 = 4.
- Range error: enter 2, then data_in=100. Required: error=1, count stays 1, y field 0 stays 0, ready never asserts even after input_done.
- Early done: enter 2,3,5, then input_done=1. Required: error=1, ready=0; further enter presses do not change count.
- Overflow and simultaneity: enter 6 values, then an enter pulse with data_in=7 in the same cycle as input_done. Required: overflow error=1, ready=0. Separately, raise the 6th enter edge together with input_done held for 2 cycles. Required: the value is stored, then ready=1 on the following cycle.
- Reset mid-entry: after 3 values, pulse rst for 1 cycle. Required: count=0, data fields cleared, ones fields restored to 1, error=0, ready=0. Then a nominal load succeeds.
